// File: rtl/counter8_seq_pkg.sv
// Shared definitions for the counter8 sequencer: widths, FSM states, command opcodes.
package counter8_seq_pkg;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned OP_W  = 2;

    // Sequencer states (3-bit encoding)
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Command opcodes carried on cmd_op
    typedef enum logic [OP_W-1:0] {
        CMD_START  = 2'b00,
        CMD_PAUSE  = 2'b01,
        CMD_RESUME = 2'b10,
        CMD_ABORT  = 2'b11
    } cmd_op_e;

    // Distance the counter has to travel, modulo 2**CNT_W
    function automatic logic [CNT_W-1:0] span_f(input logic [CNT_W-1:0] start_v,
                                                 input logic [CNT_W-1:0] target_v);
        return CNT_W'(target_v - start_v);
    endfunction

    // Count value one step before the target, modulo 2**CNT_W
    function automatic logic [CNT_W-1:0] pre_target_f(input logic [CNT_W-1:0] target_v);
        return CNT_W'(target_v - CNT_W'(1));
    endfunction

endpackage : counter8_seq_pkg

// File: rtl/counter8_seq_if.sv
// Command handshake plus counter8 control/observation bundle for the sequencer.
interface counter8_seq_if
    import counter8_seq_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) ();

    // Command channel
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [WIDTH-1:0] cmd_start;
    logic [WIDTH-1:0] cmd_target;
    logic             cmd_reload;

    // Counter8 side
    logic [WIDTH-1:0] ctr_count;
    logic [WIDTH-1:0] ctr_data;
    logic             ctr_load;
    logic             ctr_start_stop;

    // Status
    logic             busy;
    logic             done;
    logic             cmd_err;

    // Control logic / counter side
    modport master (
        output cmd_valid, cmd_op, cmd_start, cmd_target, cmd_reload, ctr_count,
        input  cmd_ready, ctr_data, ctr_load, ctr_start_stop, busy, done, cmd_err
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_start, cmd_target, cmd_reload, ctr_count,
        output cmd_ready, ctr_data, ctr_load, ctr_start_stop, busy, done, cmd_err
    );

endinterface : counter8_seq_if

// File: rtl/counter8.sv
// 8-bit loadable up-counter driven by the sequencer; load has priority over counting.
module counter8
    import counter8_seq_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic             start_stop,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Load wins; otherwise increment with natural wrap when enabled
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= data;
        end else if (start_stop) begin
            count_q <= WIDTH'(count_q + WIDTH'(1));
        end
    end

    assign count = count_q;

endmodule : counter8

// File: rtl/counter8_seq.sv
// Sequencer for counter8: accepts START/PAUSE/RESUME/ABORT commands, loads the start
// value, runs the counter to the programmed target (wrapping through 255) and
// optionally reloads for periodic operation.
module counter8_seq
    import counter8_seq_pkg::*;
(
    input  logic           clock,
    input  logic           clear,
    counter8_seq_if.slave  bus
);

    localparam int unsigned WIDTH = CNT_W;

    state_e           state_q;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] target_q;
    logic             reload_q;
    logic [WIDTH-1:0] data_q;
    logic             load_q;
    logic             run_q;
    logic             done_q;
    logic             err_q;

    cmd_op_e          op;
    logic             accept;
    logic             at_term;
    logic [WIDTH-1:0] span;

    // Command decode; the counter is one step short of target on the terminal edge
    assign op      = cmd_op_e'(bus.cmd_op);
    assign accept  = bus.cmd_valid && (state_q != LOAD);
    assign span    = span_f(start_q, target_q);
    assign at_term = (bus.ctr_count == pre_target_f(target_q));

    // Main sequencer FSM with registered counter controls and status pulses
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= IDLE;
            start_q  <= '0;
            target_q <= '0;
            reload_q <= 1'b0;
            data_q   <= '0;
            load_q   <= 1'b0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        case (op)
                            CMD_START: begin
                                start_q  <= bus.cmd_start;
                                target_q <= bus.cmd_target;
                                reload_q <= bus.cmd_reload;
                                data_q   <= bus.cmd_start;
                                load_q   <= 1'b1;
                                state_q  <= LOAD;
                            end
                            CMD_ABORT: begin
                                run_q   <= 1'b0;
                                load_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end

                LOAD: begin
                    // Counter takes data_q on this edge
                    load_q <= 1'b0;
                    if (span == '0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        run_q   <= 1'b1;
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    if (accept && (op == CMD_ABORT)) begin
                        // Abort wins over terminal detect: no done pulse
                        run_q   <= 1'b0;
                        load_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (at_term) begin
                        // Any other command on the terminal edge is dropped as illegal
                        run_q  <= 1'b0;
                        done_q <= 1'b1;
                        if (accept) begin
                            err_q <= 1'b1;
                        end
                        if (reload_q && (span != '0)) begin
                            data_q  <= start_q;
                            load_q  <= 1'b1;
                            state_q <= LOAD;
                        end else begin
                            state_q <= DONE;
                        end
                    end else if (accept) begin
                        if (op == CMD_PAUSE) begin
                            run_q   <= 1'b0;
                            state_q <= PAUSE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end

                PAUSE: begin
                    if (accept) begin
                        case (op)
                            CMD_RESUME: begin
                                run_q   <= 1'b1;
                                state_q <= RUN;
                            end
                            CMD_ABORT: begin
                                run_q   <= 1'b0;
                                load_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end

                default: begin
                    run_q   <= 1'b0;
                    load_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs: ready/busy decode the state, the rest come straight from registers
    assign bus.cmd_ready      = (state_q != LOAD);
    assign bus.busy           = (state_q == LOAD) || (state_q == RUN) || (state_q == PAUSE);
    assign bus.ctr_data       = data_q;
    assign bus.ctr_load       = load_q;
    assign bus.ctr_start_stop = run_q;
    assign bus.done           = done_q;
    assign bus.cmd_err        = err_q;

endmodule : counter8_seq

// File: tb/tb_counter8_seq.sv
// Directed bench for counter8_seq driving a real counter8 instance.
module tb_counter8_seq;
    import counter8_seq_pkg::*;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    counter8_seq_if #(.WIDTH(8)) bus ();

    counter8_seq dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    counter8 #(.WIDTH(8)) u_ctr (
        .clock      (clock),
        .clear      (clear),
        .load       (bus.ctr_load),
        .start_stop (bus.ctr_start_stop),
        .data       (bus.ctr_data),
        .count      (bus.ctr_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] s, input logic [7:0] t,
                         input logic r);
        bus.cmd_op     = op;
        bus.cmd_start  = s;
        bus.cmd_target = t;
        bus.cmd_reload = r;
        bus.cmd_valid  = 1'b1;
        tick();
        bus.cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00;
        bus.cmd_start = 8'd0; bus.cmd_target = 8'd0; bus.cmd_reload = 1'b0;
        #12;
        n_checks++;
        if ({bus.ctr_data, bus.ctr_load, bus.ctr_start_stop, bus.done, bus.cmd_err} !== 12'h000) begin
            n_fail++; $display("FAIL reset_outs: got %h want 000",
                {bus.ctr_data, bus.ctr_load, bus.ctr_start_stop, bus.done, bus.cmd_err});
        end
        n_checks++;
        if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
            n_fail++; $display("FAIL reset_ready_busy: got %b want 10", {bus.cmd_ready, bus.busy});
        end
        n_checks++;
        if (bus.ctr_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", bus.ctr_count);
        end
        @(negedge clock);
        clear = 1'b0;
        tick(); tick();
        n_checks++;
        if ({bus.busy, bus.done, bus.ctr_start_stop} !== 3'b000) begin
            n_fail++; $display("FAIL idle_quiet: got %b want 000", {bus.busy, bus.done, bus.ctr_start_stop});
        end
    endtask

    task automatic test_basic();
        logic [7:0] ec;
        logic       ed;
        issue(CMD_START, 8'd0, 8'd5, 1'b0);
        n_checks++;
        if ({bus.ctr_load, bus.ctr_data, bus.cmd_ready, bus.busy} !== {1'b1, 8'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL basic_load: got %h want %h",
                {bus.ctr_load, bus.ctr_data, bus.cmd_ready, bus.busy}, {1'b1, 8'd0, 1'b0, 1'b1});
        end
        tick();
        n_checks++;
        if ({bus.ctr_count, bus.ctr_start_stop, bus.ctr_load} !== {8'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL basic_run_entry: got %h want %h",
                {bus.ctr_count, bus.ctr_start_stop, bus.ctr_load}, {8'd0, 1'b1, 1'b0});
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            ec = 8'(i); ed = (i == 5);
            n_checks++;
            if ({bus.ctr_count, bus.done} !== {ec, ed}) begin
                n_fail++; $display("FAIL basic_step%0d: count/done got %0d/%b want %0d/%b",
                    i, bus.ctr_count, bus.done, ec, ed);
            end
        end
        n_checks++;
        if ({bus.ctr_start_stop, bus.busy, dut.state_q} !== {1'b0, 1'b0, DONE}) begin
            n_fail++; $display("FAIL basic_done_state: got %h want %h",
                {bus.ctr_start_stop, bus.busy, dut.state_q}, {1'b0, 1'b0, DONE});
        end
        tick();
        n_checks++;
        if ({bus.ctr_count, bus.done} !== {8'd5, 1'b0}) begin
            n_fail++; $display("FAIL basic_hold: count/done got %0d/%b want 5/0", bus.ctr_count, bus.done);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ec;
        logic       ed;
        issue(CMD_START, 8'd250, 8'd3, 1'b0);
        n_checks++;
        if ({bus.ctr_load, bus.ctr_data} !== {1'b1, 8'd250}) begin
            n_fail++; $display("FAIL wrap_load: got %h want %h", {bus.ctr_load, bus.ctr_data}, {1'b1, 8'd250});
        end
        tick();
        n_checks++;
        if (bus.ctr_count !== 8'd250) begin
            n_fail++; $display("FAIL wrap_start: got %0d want 250", bus.ctr_count);
        end
        for (int i = 1; i <= 9; i++) begin
            tick();
            ec = 8'(250 + i); ed = (i == 9);
            n_checks++;
            if ({bus.ctr_count, bus.done} !== {ec, ed}) begin
                n_fail++; $display("FAIL wrap_step%0d: count/done got %0d/%b want %0d/%b",
                    i, bus.ctr_count, bus.done, ec, ed);
            end
        end
        tick();
        n_checks++;
        if ({bus.ctr_count, bus.ctr_start_stop, bus.done} !== {8'd3, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL wrap_after: got %h want %h",
                {bus.ctr_count, bus.ctr_start_stop, bus.done}, {8'd3, 1'b0, 1'b0});
        end
    endtask

    task automatic test_reload();
        logic [7:0] ec;
        logic       ed;
        issue(CMD_START, 8'd2, 8'd4, 1'b1);
        tick();
        n_checks++;
        if ({bus.ctr_count, bus.ctr_start_stop} !== {8'd2, 1'b1}) begin
            n_fail++; $display("FAIL reload_entry: got %h want %h", {bus.ctr_count, bus.ctr_start_stop}, {8'd2, 1'b1});
        end
        for (int i = 1; i <= 7; i++) begin
            tick();
            ec = 8'(2 + (i % 3)); ed = ((i % 3) == 2);
            n_checks++;
            if ({bus.ctr_count, bus.done, bus.ctr_load} !== {ec, ed, ed}) begin
                n_fail++; $display("FAIL reload_step%0d: count/done/load got %0d/%b/%b want %0d/%b/%b",
                    i, bus.ctr_count, bus.done, bus.ctr_load, ec, ed, ed);
            end
        end
        // Count is 3 here: the ABORT lands on the terminal edge and must suppress done
        issue(CMD_ABORT, 8'd0, 8'd0, 1'b0);
        n_checks++;
        if ({bus.ctr_count, bus.done, bus.ctr_start_stop, bus.busy, dut.state_q} !== {8'd4, 1'b0, 1'b0, 1'b0, IDLE}) begin
            n_fail++; $display("FAIL reload_abort: got %h want %h",
                {bus.ctr_count, bus.done, bus.ctr_start_stop, bus.busy, dut.state_q},
                {8'd4, 1'b0, 1'b0, 1'b0, IDLE});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({bus.ctr_count, bus.done, bus.ctr_load} !== {8'd4, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL reload_quiet%0d: count/done/load got %0d/%b/%b want 4/0/0",
                    i, bus.ctr_count, bus.done, bus.ctr_load);
            end
        end
    endtask

    task automatic test_pause();
        logic [7:0] ec;
        logic       ed;
        issue(CMD_START, 8'd0, 8'd10, 1'b0);
        tick();
        for (int i = 1; i <= 4; i++) tick();
        n_checks++;
        if (bus.ctr_count !== 8'd4) begin
            n_fail++; $display("FAIL pause_pre: got %0d want 4", bus.ctr_count);
        end
        issue(CMD_PAUSE, 8'd0, 8'd0, 1'b0);
        n_checks++;
        if ({bus.ctr_count, bus.ctr_start_stop, bus.busy, bus.cmd_err} !== {8'd5, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL pause_enter: got %h want %h",
                {bus.ctr_count, bus.ctr_start_stop, bus.busy, bus.cmd_err}, {8'd5, 1'b0, 1'b1, 1'b0});
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if ({bus.ctr_count, bus.done} !== {8'd5, 1'b0}) begin
                n_fail++; $display("FAIL pause_hold%0d: count/done got %0d/%b want 5/0", i, bus.ctr_count, bus.done);
            end
        end
        issue(CMD_RESUME, 8'd0, 8'd0, 1'b0);
        n_checks++;
        if ({bus.ctr_count, bus.ctr_start_stop} !== {8'd5, 1'b1}) begin
            n_fail++; $display("FAIL pause_resume: got %h want %h", {bus.ctr_count, bus.ctr_start_stop}, {8'd5, 1'b1});
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            ec = 8'(5 + i); ed = (i == 5);
            n_checks++;
            if ({bus.ctr_count, bus.done} !== {ec, ed}) begin
                n_fail++; $display("FAIL resume_step%0d: count/done got %0d/%b want %0d/%b",
                    i, bus.ctr_count, bus.done, ec, ed);
            end
        end
    endtask

    task automatic test_illegal();
        issue(CMD_ABORT, 8'd0, 8'd0, 1'b0);
        n_checks++;
        if ({bus.cmd_err, bus.busy, dut.state_q} !== {1'b0, 1'b0, IDLE}) begin
            n_fail++; $display("FAIL abort_done: got %h want %h", {bus.cmd_err, bus.busy, dut.state_q}, {1'b0, 1'b0, IDLE});
        end
        issue(CMD_RESUME, 8'd0, 8'd0, 1'b0);
        n_checks++;
        if ({bus.cmd_err, dut.state_q, bus.ctr_start_stop} !== {1'b1, IDLE, 1'b0}) begin
            n_fail++; $display("FAIL resume_idle: got %h want %h",
                {bus.cmd_err, dut.state_q, bus.ctr_start_stop}, {1'b1, IDLE, 1'b0});
        end
        tick();
        n_checks++;
        if (bus.cmd_err !== 1'b0) begin
            n_fail++; $display("FAIL err_pulse_len: got %b want 0", bus.cmd_err);
        end
        issue(CMD_START, 8'd0, 8'd20, 1'b0);
        tick();
        issue(CMD_START, 8'd100, 8'd99, 1'b1);
        n_checks++;
        if ({bus.cmd_err, dut.state_q, dut.target_q, bus.ctr_count} !== {1'b1, RUN, 8'd20, 8'd1}) begin
            n_fail++; $display("FAIL start_in_run: got %h want %h",
                {bus.cmd_err, dut.state_q, dut.target_q, bus.ctr_count}, {1'b1, RUN, 8'd20, 8'd1});
        end
        for (int i = 0; i < 18; i++) tick();
        n_checks++;
        if ({bus.ctr_count, bus.done, bus.cmd_err} !== {8'd19, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL pre_term: got %h want %h", {bus.ctr_count, bus.done, bus.cmd_err}, {8'd19, 1'b0, 1'b0});
        end
        // PAUSE on the terminal edge loses to terminal detect
        issue(CMD_PAUSE, 8'd0, 8'd0, 1'b0);
        n_checks++;
        if ({bus.done, bus.cmd_err, bus.ctr_count, bus.ctr_start_stop, dut.state_q} !== {1'b1, 1'b1, 8'd20, 1'b0, DONE}) begin
            n_fail++; $display("FAIL term_vs_pause: got %h want %h",
                {bus.done, bus.cmd_err, bus.ctr_count, bus.ctr_start_stop, dut.state_q},
                {1'b1, 1'b1, 8'd20, 1'b0, DONE});
        end
    endtask

    task automatic test_zero_span();
        issue(CMD_START, 8'd7, 8'd7, 1'b0);
        n_checks++;
        if ({bus.ctr_load, bus.ctr_data, bus.ctr_start_stop, bus.done} !== {1'b1, 8'd7, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL zero_load: got %h want %h",
                {bus.ctr_load, bus.ctr_data, bus.ctr_start_stop, bus.done}, {1'b1, 8'd7, 1'b0, 1'b0});
        end
        tick();
        n_checks++;
        if ({bus.done, bus.ctr_start_stop, bus.ctr_count, dut.state_q} !== {1'b1, 1'b0, 8'd7, DONE}) begin
            n_fail++; $display("FAIL zero_done: got %h want %h",
                {bus.done, bus.ctr_start_stop, bus.ctr_count, dut.state_q}, {1'b1, 1'b0, 8'd7, DONE});
        end
        tick();
        n_checks++;
        if ({bus.done, bus.ctr_start_stop, bus.ctr_count} !== {1'b0, 1'b0, 8'd7}) begin
            n_fail++; $display("FAIL zero_after: got %h want %h",
                {bus.done, bus.ctr_start_stop, bus.ctr_count}, {1'b0, 1'b0, 8'd7});
        end
    endtask

    task automatic test_async_reset();
        issue(CMD_START, 8'd0, 8'd9, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if ({bus.ctr_count, bus.busy} !== {8'd3, 1'b1}) begin
            n_fail++; $display("FAIL arst_pre: got %h want %h", {bus.ctr_count, bus.busy}, {8'd3, 1'b1});
        end
        #2;
        clear = 1'b1;
        #1;
        n_checks++;
        if ({bus.ctr_data, bus.ctr_load, bus.ctr_start_stop, bus.done, bus.cmd_err,
             bus.cmd_ready, bus.busy, bus.ctr_count} !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0}) begin
            n_fail++; $display("FAIL arst_outs: got %h want %h",
                {bus.ctr_data, bus.ctr_load, bus.ctr_start_stop, bus.done, bus.cmd_err,
                 bus.cmd_ready, bus.busy, bus.ctr_count},
                {8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
        end
        n_checks++;
        if ({dut.state_q, dut.target_q} !== {IDLE, 8'd0}) begin
            n_fail++; $display("FAIL arst_state: got %h want %h", {dut.state_q, dut.target_q}, {IDLE, 8'd0});
        end
        tick();
        @(negedge clock);
        clear = 1'b0;
        tick();
        n_checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            n_fail++; $display("FAIL arst_release: got %b want 00", {bus.done, bus.busy});
        end
        issue(CMD_START, 8'd0, 8'd2, 1'b0);
        tick();
        tick();
        n_checks++;
        if ({bus.ctr_count, bus.done} !== {8'd1, 1'b0}) begin
            n_fail++; $display("FAIL arst_run1: count/done got %0d/%b want 1/0", bus.ctr_count, bus.done);
        end
        tick();
        n_checks++;
        if ({bus.ctr_count, bus.done} !== {8'd2, 1'b1}) begin
            n_fail++; $display("FAIL arst_done: count/done got %0d/%b want 2/1", bus.ctr_count, bus.done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_reload();
        test_pause();
        test_illegal();
        test_zero_span();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule : tb_counter8_seq
